branch_predictor_unit: RTL

- Fetch-stage branch classifier plus dynamic direction predictor.
- Decodes the fetched opcode into a branch kind and produces a taken prediction from a pattern history table (PHT) of 2-bit saturating counters.
- The PHT is trained by branch resolutions from execute.
- Replaces the purely combinational classifier; also keeps saturating branch/mispredict statistics counters.

---
 rtl/branch_predictor_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/branch_predictor_unit.sv
// branch_predictor_unit
//   Fetch-stage branch classifier plus a dynamic direction predictor built
//   from a pattern history table (PHT) of 2-bit saturating counters. The PHT
//   is trained by branch resolutions from execute. Saturating statistics
//   counters track resolved and mispredicted conditional branches.
//
//   Optional feature: define BRANCH_GSHARE_EN to add an IDX_W-bit global
//   history register that is XORed into the fetch index (gshare). The
//   default build (macro undefined) uses the PC index alone and has no
//   history flops.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   f_op, f_pc        opcode and PC of the instruction in fetch
//   f_kind            00 none, 01 uncond, 10 reg-compare, 11 imm-compare
//   f_taken           predicted redirect for the fetched instruction
//   f_idx             PHT index used; returned later as u_idx
//   u_valid           one conditional branch resolves this cycle
//   u_idx             PHT index carried from fetch
//   u_taken           actual branch direction
//   u_mispredict      prediction was wrong (ignored without u_valid)
//   stat_branches     resolved conditional branches (saturating)
//   stat_mispredicts  mispredicted branches (saturating)
module branch_predictor_unit #(
    parameter int PC_W             = 32,
    parameter int IDX_W            = 8,
    parameter int PC_SHIFT         = 0,
    parameter int STAT_W           = 32,
    parameter int IMM_STATIC_TAKEN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        f_op,
    input  logic [PC_W-1:0]   f_pc,
    output logic [1:0]        f_kind,
    output logic              f_taken,
    output logic [IDX_W-1:0]  f_idx,
    input  logic              u_valid,
    input  logic [IDX_W-1:0]  u_idx,
    input  logic              u_taken,
    input  logic              u_mispredict,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } pht_state_t;

    pht_state_t pht [DEPTH];
    pht_state_t pht_rd;
    logic [IDX_W-1:0] pc_idx;

    // Only a slice of the PC forms the index; the rest is folded here so the
    // remaining bits are visibly consumed.
    logic unused_pc_bits;
    assign unused_pc_bits = ^f_pc;

    assign pc_idx = f_pc[PC_SHIFT+IDX_W-1:PC_SHIFT];

`ifdef BRANCH_GSHARE_EN
    logic [IDX_W-1:0] ghr;

    always_ff @(posedge clk) begin
        if (reset) begin
            ghr <= '0;
        end else if (u_valid) begin
            // History advances only at resolution (non-speculative).
            ghr <= {ghr[IDX_W-2:0], u_taken};
        end
    end

    assign f_idx = pc_idx ^ ghr;
`else
    assign f_idx = pc_idx;
`endif

    // Opcode classification.
    always_comb begin
        f_kind = 2'b00;
        case (f_op)
            6'b100000, 6'b100001:                       f_kind = 2'b01;
            6'b100100, 6'b100101, 6'b100110,
            6'b100111, 6'b101000, 6'b101001:            f_kind = 2'b10;
            6'b110000, 6'b111000:                       f_kind = 2'b11;
            default:                                    f_kind = 2'b00;
        endcase
    end

    // Prediction reads the pre-update PHT contents, so a same-cycle update to
    // the same entry becomes visible only on the following cycle.
    assign pht_rd = pht[f_idx];

    always_comb begin
        f_taken = 1'b0;
        case (f_kind)
            2'b00: f_taken = 1'b0;
            2'b01: f_taken = 1'b1;
            2'b10: f_taken = pht_rd[1];
            2'b11: f_taken = (IMM_STATIC_TAKEN != 0) ? 1'b1 : pht_rd[1];
            default: f_taken = 1'b0;
        endcase
    end

    // PHT training: one entry per update, saturating at SNT/ST.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pht[i[IDX_W-1:0]] <= WNT;
            end
        end else if (u_valid) begin
            case (pht[u_idx])
                SNT:     pht[u_idx] <= u_taken ? WNT : SNT;
                WNT:     pht[u_idx] <= u_taken ? WT  : SNT;
                WT:      pht[u_idx] <= u_taken ? ST  : WNT;
                ST:      pht[u_idx] <= u_taken ? ST  : WT;
                default: pht[u_idx] <= WNT;
            endcase
        end
    end

    // Saturating statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (u_valid) begin
            if (stat_branches != '1) begin
                stat_branches <= stat_branches + 1'b1;
            end
            if (u_mispredict && (stat_mispredicts != '1)) begin
                stat_mispredicts <= stat_mispredicts + 1'b1;
            end
        end
    end

endmodule
